// File: rtl/zx_dma_arbiter.sv
// Shares RAM port A between the Z80 and a DMA requester.
// The bus is taken with the nBUSRQ/nBUSACK handshake and each DMA grant is time-limited.
module zx_dma_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int READ_LAT = 2,
  parameter int HOLD_MAX = 256,
  parameter int GAP_MIN  = 64
) (
  input  logic              clock_25,
  input  logic              RESET_N,
  input  logic              i_cpu_nbusack,
  output logic              o_cpu_nbusrq,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  input  logic              i_cpu_we,
  input  logic              i_dma_req,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [7:0]        i_dma_wdata,
  input  logic              i_dma_we,
  input  logic              i_dma_last,
  output logic              o_dma_ack,
  output logic [7:0]        o_dma_rdata,
  output logic              o_dma_rvalid,
  input  logic [7:0]        i_mem_q,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_wren,
  output logic              o_dma_owner
);

  localparam int BEAT_W = $clog2(HOLD_MAX + 1);
  localparam int GAP_W  = $clog2(GAP_MIN + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_GRANT    = 3'd2,
    S_DRAIN    = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_ack_meta;
  logic                r_ack_s;
  logic                r_nbusrq;
  logic                r_owner;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [READ_LAT-1:0] r_rd_pipe;

  logic                w_beat;
  logic                w_rd_beat;
  logic                w_hold_hit;
  logic                w_pipe_drained;
  logic [READ_LAT-1:0] w_pipe_shift;

  assign w_beat         = (r_state == S_GRANT) && i_dma_req;
  assign w_rd_beat      = w_beat && !i_dma_we;
  assign w_hold_hit     = (r_beat_cnt == BEAT_W'(HOLD_MAX - 1));
  assign w_pipe_shift   = r_rd_pipe << 1'b1;
  // Only the last stage may still be busy: it delivers in this very cycle.
  assign w_pipe_drained = (w_pipe_shift == {READ_LAT{1'b0}});

  // Two-flop synchronizer for the asynchronous nBUSACK.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      r_ack_meta <= 1'b1;
      r_ack_s    <= 1'b1;
    end else begin
      r_ack_meta <= i_cpu_nbusack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Read-beat tracker: one bit per beat in flight, aligned to the RAM read latency.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      r_rd_pipe <= {READ_LAT{1'b0}};
    end else begin
      r_rd_pipe <= w_pipe_shift | READ_LAT'(w_rd_beat);
    end
  end

  // Bus ownership FSM with hold limit and post-release gap.
  always_ff @(posedge clock_25) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_nbusrq   <= 1'b1;
      r_owner    <= 1'b0;
      r_gap_cnt  <= {GAP_W{1'b0}};
      r_beat_cnt <= {BEAT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_gap_cnt != {GAP_W{1'b0}}) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else if (i_dma_req) begin
            r_state  <= S_REQ;
            r_nbusrq <= 1'b0;
          end
        end
        S_REQ: begin
          if (!r_ack_s) begin
            r_state    <= S_GRANT;
            r_owner    <= 1'b1;
            r_beat_cnt <= {BEAT_W{1'b0}};
          end
        end
        S_GRANT: begin
          if (!i_dma_req) begin
            r_state <= S_DRAIN;
          end else begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            if (i_dma_last || w_hold_hit) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pipe_drained) begin
            r_state  <= S_WAIT_REL;
            r_owner  <= 1'b0;
            r_nbusrq <= 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (r_ack_s) begin
            r_gap_cnt <= GAP_W'(GAP_MIN);
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_nbusrq <= 1'b1;
          r_owner  <= 1'b0;
        end
      endcase
    end
  end

  // Port A mux: the select is only the registered owner flag.
  always_comb begin
    o_mem_addr = i_cpu_addr;
    o_mem_data = i_cpu_wdata;
    o_mem_wren = 1'b0;
    if (r_owner) begin
      o_mem_addr = i_dma_addr;
      o_mem_data = i_dma_wdata;
      o_mem_wren = w_beat && i_dma_we;
    end else begin
      o_mem_addr = i_cpu_addr;
      o_mem_data = i_cpu_wdata;
      o_mem_wren = i_cpu_we && RESET_N;
    end
  end

  assign o_cpu_nbusrq = r_nbusrq;
  assign o_dma_owner  = r_owner;
  assign o_dma_ack    = w_beat;
  assign o_dma_rvalid = r_rd_pipe[READ_LAT-1];
  assign o_dma_rdata  = r_rd_pipe[READ_LAT-1] ? i_mem_q : 8'h00;

endmodule
